klt_update_ctrl: RTL
====================

// Module: klt_update_ctrl
// PURPOSE
//  Per-frame update sequencer for klt_tracker. Latches the final G11/G12/G22/b1/b2 sums and solves G*d=b.
//  Uses one shared signed multiplier and a sequential divider, then updates the tracked point (point_x0/point_y0).
//  Commits the new point at the next frame start, so the tracker ROI stays stable within a frame.
// PARAMETERS
//  ACC_W    26    width of the signed G/b sums
//  DX_W     16    width of signed displacement dx_q/dy_q (fixed point)
//  FRAC     4     fractional bits of dx_q/dy_q
//  IMG_W    1920  active width in pixels
//  IMG_H    1080  active height in lines
//  HALF_WIN 7     ROI half-window; point clamped to [HALF_WIN, IMG-1-HALF_WIN]
//  INIT_X   960   point_x0 after rst/reset_position
//  INIT_Y   540   point_y0 after rst/reset_position
// PORTS
//  rx_pclk          in   1      pixel clock; only clock
//  rst              in   1      synchronous, active-high reset
//  rx_vsync         in   1      frame sync; a rising edge marks frame start (commit point)
//  enable_tracking  in   1      0: ignore acc_valid and hold the point
//  reset_position   in   1      abort computation; pending point := INIT
//  acc_valid        in   1      1-cycle pulse; G/b inputs are final this cycle
//  G11,G12,G22      in   ACC_W  signed structure-tensor sums
//  b1,b2            in   ACC_W  signed mismatch sums
//  point_x0         out  12     committed ROI centre x
//  point_y0         out  11     committed ROI centre y
//  dx_q,dy_q        out  DX_W   last solved displacement, signed, FRAC fractional bits
//  upd_valid        out  1      1-cycle pulse when dx_q/dy_q and the pending point are updated
//  busy             out  1      high while not in IDLE
//  singular         out  1      last solve had det<=0; holds until the next solve
//  overrun          out  1      sticky: acc_valid arrived while busy; cleared by rst only
// BEHAVIOUR
//  - Reset values: point_x0=INIT_X, point_y0=INIT_Y, pending point=INIT.
//    dx_q=dy_q=0; upd_valid=busy=singular=overrun=0; FSM in IDLE.
//  - rx_vsync is registered once and edge-detected on the registered copy.
//    On a rising edge, point_x0/point_y0 := pending point, in the same cycle as the edge is detected.
//  - FSM states: IDLE, MUL, CHK, DIVX, DIVY, APPLY.
//    - IDLE: acc_valid & enable_tracking -> latch the 5 inputs, go to MUL.
//    - MUL, 7 cycles: one ACC_W x ACC_W signed multiplier with a registered output, one product per cycle.
//      Product order: G11*G22, G12*G12, G22*b1, G12*b2, G11*b2, G12*b1, then 1 drain cycle.
//      det = G11*G22 - G12^2; nx = G22*b1 - G12*b2; ny = G11*b2 - G12*b1; all 2*ACC_W+1 signed.
//    - CHK, 1 cycle: det<=0 -> singular=1, dx_q=dy_q=0, go to APPLY (point unchanged).
//      Otherwise singular=0, go to DIVX.
//    - DIVX / DIVY, DX_W cycles each: q = (|n| << FRAC) / det, unsigned, then the sign of n is applied.
//      If (|n| << FRAC) >= (det << (DX_W-1)), the result saturates to +/-(2^(DX_W-1)-1).
//    - APPLY, 1 cycle: upd_valid=1.
//      pending = clamp(point + ((q + 2^(FRAC-1)) >>> FRAC)), computed at 14-bit signed width.
//      The base is the committed point. Then go to IDLE.
//  - Latency: upd_valid is high exactly 2*DX_W+9 cycles after the acc_valid cycle (41 at defaults).
//  - acc_valid while busy: ignored, overrun:=1. acc_valid with enable_tracking=0: ignored, no flag.
//  - reset_position (any state): FSM -> IDLE, pending := INIT, no upd_valid.
//    The committed point changes only at the next vsync rise. reset_position wins over a same-cycle acc_valid.
//  - vsync rise during a computation: commits the old pending point. The running solve continues.
//    Its result is committed at the following frame.
//  - APPLY and vsync rise in the same cycle: the commit uses the old pending value.
//    The new value is committed next frame.
//  - rst mid-operation: all state returns to reset values in the next cycle.
// STRUCTURE
//  - Shared package klt_pkg: ACC_W, DX_W, FRAC, image/window constants, FSM state encoding.
//  - Sub-module klt_seq_div: unsigned restoring divider, 1 quotient bit per cycle.
//    Interface: start/dividend/divisor -> done/quotient/ovf.
//    Instantiated once; used by DIVX, then DIVY.
//  - Multiplier, sign handling, rounding and clamp are inline in klt_update_ctrl.
// TESTING
//  1. Basic solve: G11=G22=100, G12=0, b1=200, b2=-100, point (960,540).
//     -> upd_valid at +41 cycles; dx_q=32, dy_q=-16.
//     -> Next vsync rise: point = (962,539).
//  2. Singular: G11=G12=G22=4, b1=b2=8 -> singular=1, dx_q=dy_q=0, upd_valid pulses, point unchanged.
//  3. Clamp and saturation:
//     - point_x0=1905, solve gives dx_q=320 -> point_x0=1912 after vsync.
//     - G11=G22=1, G12=0, b1=2^24 -> dx_q=32767.
//  4. Abort: reset_position high 20 cycles after acc_valid -> no upd_valid, busy=0 next cycle.
//     -> Point = (960,540) at the next vsync rise.
//  5. Gating:
//     - enable_tracking=0 with acc_valid -> busy stays 0.
//     - A second acc_valid 10 cycles into a solve -> overrun=1, first result still delivered at +41.
//  6. Frame overlap: vsync rise mid-solve -> the old point is committed.
//     -> The solved point appears only at the following vsync rise; rst mid-solve -> all outputs return to reset values.

Source files
------------

// File: rtl/klt_pkg.sv
// Shared constants, FSM encoding and small arithmetic helpers for the KLT
// tracker update path.
package klt_pkg;

  localparam int ACC_W    = 26;    // signed G/b sum width
  localparam int DX_W     = 16;    // signed displacement width
  localparam int FRAC     = 4;     // fractional bits of the displacement
  localparam int IMG_W    = 1920;
  localparam int IMG_H    = 1080;
  localparam int HALF_WIN = 7;
  localparam int INIT_X   = 960;
  localparam int INIT_Y   = 540;

  localparam int PX_W  = 12;       // point_x0 width
  localparam int PY_W  = 11;       // point_y0 width
  localparam int POS_W = 14;       // signed width used for the point update

  // Legal ROI centres keep the whole window inside the image.
  localparam int MIN_X = HALF_WIN;
  localparam int MAX_X = IMG_W - 1 - HALF_WIN;
  localparam int MIN_Y = HALF_WIN;
  localparam int MAX_Y = IMG_H - 1 - HALF_WIN;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_CHK   = 3'd2,
    ST_DIVX  = 3'd3,
    ST_DIVY  = 3'd4,
    ST_APPLY = 3'd5
  } klt_state_e;

  // Turn an unsigned quotient into the signed displacement, saturating to
  // the largest magnitude when the divider reported overflow.
  function automatic logic signed [DX_W-1:0] apply_sign(
    input logic [DX_W-1:0] q,
    input logic            ovf,
    input logic            neg
  );
    logic [DX_W-1:0] mag;
    mag = ovf ? DX_W'((1 << (DX_W - 1)) - 1) : q;
    return neg ? $signed(-mag) : $signed(mag);
  endfunction

  // Clamp a signed candidate position into [lo, hi].
  function automatic logic signed [POS_W-1:0] clamp_pos(
    input logic signed [POS_W-1:0] v,
    input int                      lo,
    input int                      hi
  );
    if (v < lo) return POS_W'(lo);
    if (v > hi) return POS_W'(hi);
    return v;
  endfunction

endpackage

// File: rtl/klt_seq_div.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// The first bit is resolved in the start cycle, so done pulses Q_W cycles
// after start. ovf flags dividend >= divisor << (Q_W-1), i.e. a quotient that
// does not fit in Q_W-1 bits; the caller saturates in that case.
module klt_seq_div #(
  parameter int DVD_W = 57,
  parameter int DVS_W = 53,
  parameter int Q_W   = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic             ovf
);

  localparam int CW    = (DVD_W > DVS_W + Q_W - 1) ? DVD_W : DVS_W + Q_W - 1;
  localparam int CNT_W = $clog2(Q_W + 1);

  logic [CW-1:0]    rem_reg, dvs_reg;
  logic [Q_W-1:0]   q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg, done_reg, ovf_reg;

  logic [CW-1:0] rem_in, dvs_in, rem_sub;
  logic          ge;

  // One trial subtraction; on start it works on the freshly loaded operands.
  always_comb begin
    rem_in  = start ? CW'(dividend) : rem_reg;
    dvs_in  = start ? (CW'(divisor) << (Q_W - 1)) : dvs_reg;
    ge      = (rem_in >= dvs_in);
    rem_sub = ge ? (rem_in - dvs_in) : rem_in;
  end

  // Iteration state: remainder, shifted divisor, quotient and bit counter.
  always_ff @(posedge clk) begin
    if (srst) begin
      rem_reg    <= '0;
      dvs_reg    <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg    <= rem_sub;
        dvs_reg    <= dvs_in >> 1;
        q_reg      <= Q_W'(ge);
        ovf_reg    <= ge;
        cnt_reg    <= CNT_W'(Q_W - 1);
        active_reg <= 1'b1;
      end else if (active_reg) begin
        rem_reg <= rem_sub;
        dvs_reg <= dvs_reg >> 1;
        q_reg   <= {q_reg[Q_W-2:0], ge};
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done     = done_reg;
  assign quotient = q_reg;
  assign ovf      = ovf_reg;

endmodule

// File: rtl/klt_update_ctrl.sv
// Per-frame update sequencer: solves G*d = b from the final structure-tensor
// sums with one shared multiplier and a sequential divider, then moves the
// tracked point. The new point becomes visible only at the next frame start
// so the ROI stays fixed for a whole frame.
module klt_update_ctrl
  import klt_pkg::*;
(
  input  logic                    rx_pclk,
  input  logic                    rst,
  input  logic                    rx_vsync,
  input  logic                    enable_tracking,
  input  logic                    reset_position,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] G11,
  input  logic signed [ACC_W-1:0] G12,
  input  logic signed [ACC_W-1:0] G22,
  input  logic signed [ACC_W-1:0] b1,
  input  logic signed [ACC_W-1:0] b2,
  output logic [PX_W-1:0]         point_x0,
  output logic [PY_W-1:0]         point_y0,
  output logic signed [DX_W-1:0]  dx_q,
  output logic signed [DX_W-1:0]  dy_q,
  output logic                    upd_valid,
  output logic                    busy,
  output logic                    singular,
  output logic                    overrun
);

  localparam int PROD_W   = 2 * ACC_W;
  localparam int SUM_W    = 2 * ACC_W + 1;
  localparam int DVD_W    = SUM_W + FRAC;
  localparam int HALF_LSB = 1 << (FRAC - 1);

  klt_state_e state_reg, state_next;

  logic signed [ACC_W-1:0]  g11_reg, g12_reg, g22_reg, b1_reg, b2_reg;
  logic [2:0]               mul_cnt_reg;
  logic signed [PROD_W-1:0] mul_a, mul_b, prod_reg;
  logic signed [SUM_W-1:0]  det_reg, nx_reg, ny_reg;
  logic signed [DX_W-1:0]   qx_reg, dx_reg, dy_reg;
  logic                     singular_reg, overrun_reg;
  logic                     vs_reg, vs_d_reg, vs_rise;
  logic [PX_W-1:0]          point_x_reg, pend_x_reg;
  logic [PY_W-1:0]          point_y_reg, pend_y_reg;

  logic                     start_solve, det_nonpos, nx_neg, ny_neg;
  logic [SUM_W-1:0]         nx_mag, ny_mag;
  logic                     div_start, div_done, div_ovf;
  logic [DVD_W-1:0]         div_dividend;
  logic [DX_W-1:0]          div_q;

  logic signed [DX_W:0]     rnd_x, rnd_y;
  logic signed [POS_W-1:0]  base_x, base_y, tgt_x, tgt_y;

  assign start_solve = (state_reg == ST_IDLE) && acc_valid && enable_tracking && !reset_position;
  assign det_nonpos  = det_reg[SUM_W-1] || (det_reg == '0);
  assign nx_neg      = nx_reg[SUM_W-1];
  assign ny_neg      = ny_reg[SUM_W-1];
  assign nx_mag      = nx_neg ? $unsigned(-nx_reg) : $unsigned(nx_reg);
  assign ny_mag      = ny_neg ? $unsigned(-ny_reg) : $unsigned(ny_reg);
  assign vs_rise     = vs_reg && !vs_d_reg;

  // State register.
  always_ff @(posedge rx_pclk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state and divider launch; reset_position aborts from any state.
  always_comb begin
    state_next   = state_reg;
    div_start    = 1'b0;
    div_dividend = '0;
    case (state_reg)
      ST_IDLE:  if (acc_valid && enable_tracking) state_next = ST_MUL;
      ST_MUL:   if (mul_cnt_reg == 3'd6) state_next = ST_CHK;
      ST_CHK: begin
        if (det_nonpos) begin
          state_next = ST_APPLY;
        end else begin
          state_next   = ST_DIVX;
          div_start    = 1'b1;
          div_dividend = {nx_mag, {FRAC{1'b0}}};
        end
      end
      ST_DIVX: begin
        if (div_done) begin
          state_next   = ST_DIVY;
          div_start    = 1'b1;
          div_dividend = {ny_mag, {FRAC{1'b0}}};
        end
      end
      ST_DIVY:  if (div_done) state_next = ST_APPLY;
      ST_APPLY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (reset_position) begin
      state_next = ST_IDLE;
      div_start  = 1'b0;
    end
  end

  // Shared multiplier operand order: det, nx, ny terms, one pair per cycle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (mul_cnt_reg)
      3'd0: begin mul_a = PROD_W'(g11_reg); mul_b = PROD_W'(g22_reg); end
      3'd1: begin mul_a = PROD_W'(g12_reg); mul_b = PROD_W'(g12_reg); end
      3'd2: begin mul_a = PROD_W'(g22_reg); mul_b = PROD_W'(b1_reg);  end
      3'd3: begin mul_a = PROD_W'(g12_reg); mul_b = PROD_W'(b2_reg);  end
      3'd4: begin mul_a = PROD_W'(g11_reg); mul_b = PROD_W'(b2_reg);  end
      3'd5: begin mul_a = PROD_W'(g12_reg); mul_b = PROD_W'(b1_reg);  end
      default: ;
    endcase
  end

  // Input latch, registered multiplier and the det/nx/ny accumulation that
  // consumes each product one cycle after it is issued.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      g11_reg     <= '0;
      g12_reg     <= '0;
      g22_reg     <= '0;
      b1_reg      <= '0;
      b2_reg      <= '0;
      mul_cnt_reg <= '0;
      prod_reg    <= '0;
      det_reg     <= '0;
      nx_reg      <= '0;
      ny_reg      <= '0;
    end else begin
      if (start_solve) begin
        g11_reg     <= G11;
        g12_reg     <= G12;
        g22_reg     <= G22;
        b1_reg      <= b1;
        b2_reg      <= b2;
        mul_cnt_reg <= '0;
      end
      if (state_reg == ST_MUL) begin
        mul_cnt_reg <= mul_cnt_reg + 3'd1;
        prod_reg    <= mul_a * mul_b;
        case (mul_cnt_reg)
          3'd1: det_reg <= SUM_W'(prod_reg);
          3'd2: det_reg <= det_reg - SUM_W'(prod_reg);
          3'd3: nx_reg  <= SUM_W'(prod_reg);
          3'd4: nx_reg  <= nx_reg - SUM_W'(prod_reg);
          3'd5: ny_reg  <= SUM_W'(prod_reg);
          3'd6: ny_reg  <= ny_reg - SUM_W'(prod_reg);
          default: ;
        endcase
      end
    end
  end

  klt_seq_div #(
    .DVD_W (DVD_W),
    .DVS_W (SUM_W),
    .Q_W   (DX_W)
  ) u_div (
    .clk      (rx_pclk),
    .srst     (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  ($unsigned(det_reg)),
    .done     (div_done),
    .quotient (div_q),
    .ovf      (div_ovf)
  );

  // Solve results: dx is parked until dy is ready so both publish together.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      qx_reg       <= '0;
      dx_reg       <= '0;
      dy_reg       <= '0;
      singular_reg <= 1'b0;
    end else if (!reset_position) begin
      if (state_reg == ST_CHK) begin
        singular_reg <= det_nonpos;
        if (det_nonpos) begin
          dx_reg <= '0;
          dy_reg <= '0;
        end
      end else if (state_reg == ST_DIVX && div_done) begin
        qx_reg <= apply_sign(div_q, div_ovf, nx_neg);
      end else if (state_reg == ST_DIVY && div_done) begin
        dx_reg <= qx_reg;
        dy_reg <= apply_sign(div_q, div_ovf, ny_neg);
      end
    end
  end

  // Sticky flag for sums that arrived while a solve was still running.
  always_ff @(posedge rx_pclk) begin
    if (rst) overrun_reg <= 1'b0;
    else if (acc_valid && enable_tracking && state_reg != ST_IDLE) overrun_reg <= 1'b1;
  end

  // Frame-start detection on a single registered copy of vsync.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      vs_reg   <= 1'b0;
      vs_d_reg <= 1'b0;
    end else begin
      vs_reg   <= rx_vsync;
      vs_d_reg <= vs_reg;
    end
  end

  // Round the displacement to whole pixels and clamp the candidate point.
  always_comb begin
    rnd_x  = ((DX_W+1)'(dx_reg) + (DX_W+1)'(HALF_LSB)) >>> FRAC;
    rnd_y  = ((DX_W+1)'(dy_reg) + (DX_W+1)'(HALF_LSB)) >>> FRAC;
    base_x = POS_W'(point_x_reg);
    base_y = POS_W'(point_y_reg);
    tgt_x  = clamp_pos(POS_W'(rnd_x) + base_x, MIN_X, MAX_X);
    tgt_y  = clamp_pos(POS_W'(rnd_y) + base_y, MIN_Y, MAX_Y);
  end

  // Pending point is written at the end of APPLY; the committed point only
  // follows it on a frame start, so a same-cycle commit sees the old value.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      point_x_reg <= PX_W'(INIT_X);
      point_y_reg <= PY_W'(INIT_Y);
      pend_x_reg  <= PX_W'(INIT_X);
      pend_y_reg  <= PY_W'(INIT_Y);
    end else begin
      if (vs_rise) begin
        point_x_reg <= pend_x_reg;
        point_y_reg <= pend_y_reg;
      end
      if (reset_position) begin
        pend_x_reg <= PX_W'(INIT_X);
        pend_y_reg <= PY_W'(INIT_Y);
      end else if (state_reg == ST_APPLY && !singular_reg) begin
        pend_x_reg <= PX_W'(tgt_x);
        pend_y_reg <= PY_W'(tgt_y);
      end
    end
  end

  assign point_x0  = point_x_reg;
  assign point_y0  = point_y_reg;
  assign dx_q      = dx_reg;
  assign dy_q      = dy_reg;
  assign upd_valid = (state_reg == ST_APPLY) && !reset_position;
  assign busy      = (state_reg != ST_IDLE);
  assign singular  = singular_reg;
  assign overrun   = overrun_reg;

endmodule
